decode_stage: RTL and testbench

- Instruction-decode pipeline stage of the 16-bit pipelined CPU.
- Sits between fetch and execute. Turns 16-bit instruction words into the control bundle the execute stage and ALU consume: alu_op, register indices, immediate, memory/writeback controls.
- Holds the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles.
- Honours downstream stall and branch flush.

---
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: decodes 16-bit instruction words into the execute
// control bundle, holds the ID/EX register and inserts load-use bubbles.
module decode_stage #(
  parameter logic [3:0] NOP_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  output logic        in_ready,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [3:0]  out_alu_op,
  output logic [2:0]  out_rd,
  output logic [2:0]  out_rs1,
  output logic [2:0]  out_rs2,
  output logic [15:0] out_imm,
  output logic        out_use_imm,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic [15:0] out_pc,
  output logic        out_illegal,
  output logic        hazard_stall
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic [15:0] pc;
  } bundle_t;

  localparam logic [3:0] ALU_ADD = 4'd0;

  bundle_t    dec;
  bundle_t    id_ex;
  logic       hazard_q;
  logic       hazard;
  logic [3:0] opcode;

  assign opcode = in_instr[15:12];

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = in_pc;
    case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        dec.alu_op    = opcode;
        dec.rd        = in_instr[11:9];
        dec.rs1       = in_instr[8:6];
        dec.rs2       = in_instr[5:3];
        dec.reg_write = 1'b1;
      end
      4'd5, 4'd6, 4'd7: begin
        dec.alu_op  = ALU_ADD;
        dec.rd      = in_instr[11:9];
        dec.rs1     = in_instr[8:6];
        dec.imm     = {{10{in_instr[5]}}, in_instr[5:0]};
        dec.use_imm = 1'b1;
        if (opcode == 4'd7) begin
          dec.rs2       = in_instr[11:9];
          dec.mem_write = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.mem_read  = (opcode == 4'd6);
        end
      end
      default: dec.illegal = (opcode != NOP_OP);
    endcase
  end

  // Decoded source fields are zero whenever the opcode does not read them, and
  // register 0 never hazards, so comparing both is enough.
  assign hazard = in_valid && id_ex.valid && id_ex.mem_read && (id_ex.rd != 3'd0) &&
                  ((dec.rs1 == id_ex.rd) || (dec.rs2 == id_ex.rd));

  assign in_ready = !rst && !ex_stall && !hazard;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex    <= '0;
      hazard_q <= 1'b0;
    end else if (flush) begin
      id_ex    <= '0;
      hazard_q <= 1'b0;
    end else if (ex_stall) begin
      id_ex    <= id_ex;
      hazard_q <= hazard_q;
    end else if (hazard) begin
      id_ex    <= '0;
      hazard_q <= 1'b1;
    end else if (in_valid) begin
      id_ex    <= dec;
      hazard_q <= 1'b0;
    end else begin
      id_ex    <= '0;
      hazard_q <= 1'b0;
    end
  end

  assign out_valid     = id_ex.valid;
  assign out_alu_op    = id_ex.alu_op;
  assign out_rd        = id_ex.rd;
  assign out_rs1       = id_ex.rs1;
  assign out_rs2       = id_ex.rs2;
  assign out_imm       = id_ex.imm;
  assign out_use_imm   = id_ex.use_imm;
  assign out_reg_write = id_ex.reg_write;
  assign out_mem_read  = id_ex.mem_read;
  assign out_mem_write = id_ex.mem_write;
  assign out_illegal   = id_ex.illegal;
  assign out_pc        = id_ex.pc;
  assign hazard_stall  = hazard_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, load-use bubbles, stall/flush, reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        in_ready;
  logic        ex_stall;
  logic        flush;
  logic        out_valid;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] out_imm;
  logic        out_use_imm, out_reg_write, out_mem_read, out_mem_write;
  logic [15:0] out_pc;
  logic        out_illegal;
  logic        hazard_stall;

  int compared = 0;
  int mismatched = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_pc(out_pc),
    .out_illegal(out_illegal), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Whole observable bundle: valid,alu,rd,rs1,rs2,imm,use_imm,rw,mr,mw,illegal,hazard,pc
  logic [51:0] obs;
  assign obs = {out_valid, out_alu_op, out_rd, out_rs1, out_rs2, out_imm, out_use_imm,
                out_reg_write, out_mem_read, out_mem_write, out_illegal, hazard_stall, out_pc};

  // Controls only: valid,alu,use_imm,rw,mr,mw,illegal
  logic [9:0] ctl;
  assign ctl = {out_valid, out_alu_op, out_use_imm, out_reg_write, out_mem_read,
                out_mem_write, out_illegal};

  function automatic logic [51:0] exp_b(input logic v, input logic [3:0] alu,
      input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
      input logic [15:0] imm, input logic ui, input logic rw, input logic mr,
      input logic mw, input logic il, input logic hz, input logic [15:0] pc);
    return {v, alu, rd, rs1, rs2, imm, ui, rw, mr, mw, il, hz, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic test_reset();
    logic [51:0] exp;
    rst = 1'b1;
    drive(1'b1, 16'h0650, 16'h0010);
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (obs !== 52'h0) begin
        mismatched++;
        $display("FAIL reset_outputs[%0d]: got %h expected %h", i, obs, 52'h0);
      end
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
    end
    rst = 1'b0;
    tick();
    exp = exp_b(1, 0, 3, 1, 2, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0010);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_release_load: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_rtype();
    logic [51:0] exp;
    drive(1'b1, 16'h0650, 16'h0010);   // ADD r3,r1,r2
    tick();
    exp = exp_b(1, 0, 3, 1, 2, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0010);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL rtype_add: got %h expected %h", obs, exp);
    end
    drive(1'b1, 16'h4E5F, 16'h0012);   // XOR r7,r1,r3
    tick();
    exp = exp_b(1, 4, 7, 1, 3, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0012);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL rtype_xor: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_immediate();
    logic [51:0] exp;
    logic [25:0] got_sw, exp_sw;
    drive(1'b1, 16'h547F, 16'h0020);   // ADDI r2,r1,-1
    tick();
    exp = exp_b(1, 0, 2, 1, 0, 16'hFFFF, 1, 1, 0, 0, 0, 0, 16'h0020);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL addi_neg: got %h expected %h", obs, exp);
    end
    drive(1'b1, 16'h7A43, 16'h0030);   // SW r5,3(r1)
    tick();
    got_sw = {out_valid, out_rs1, out_rs2, out_imm, out_use_imm, out_reg_write,
              out_mem_read, out_mem_write};
    exp_sw = {1'b1, 3'd1, 3'd5, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1};
    compared++;
    if (got_sw !== exp_sw) begin
      mismatched++;
      $display("FAIL store_decode: got %h expected %h", got_sw, exp_sw);
    end
  endtask

  task automatic test_load_use();
    logic [51:0] exp;
    drive(1'b1, 16'h6842, 16'h0040);   // LW r4,2(r1)
    tick();
    exp = exp_b(1, 0, 4, 1, 0, 16'h0002, 1, 1, 1, 0, 0, 0, 16'h0040);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL load_decode: got %h expected %h", obs, exp);
    end
    drive(1'b1, 16'h0B08, 16'h0042);   // ADD r5,r4,r1
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL load_use_in_ready: got %b expected 0", in_ready);
    end
    tick();
    compared++;
    if ({out_valid, hazard_stall, in_ready} !== 3'b011) begin
      mismatched++;
      $display("FAIL load_use_bubble: got %b expected 011", {out_valid, hazard_stall, in_ready});
    end
    tick();
    exp = exp_b(1, 0, 5, 4, 1, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0042);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL load_use_issue: got %h expected %h", obs, exp);
    end
    // Load to r0 never hazards.
    drive(1'b1, 16'h6042, 16'h0050);   // LW r0,2(r1)
    tick();
    drive(1'b1, 16'h0A08, 16'h0052);   // ADD r5,r0,r1
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL r0_no_hazard_ready: got %b expected 1", in_ready);
    end
    tick();
    exp = exp_b(1, 0, 5, 0, 1, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0052);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL r0_no_hazard_issue: got %h expected %h", obs, exp);
    end
    // Store data register (instr[11:9]) is a source.
    drive(1'b1, 16'h6A42, 16'h0060);   // LW r5,2(r1)
    tick();
    drive(1'b1, 16'h7A43, 16'h0062);   // SW r5,3(r1)
    tick();
    compared++;
    if ({out_valid, hazard_stall} !== 2'b01) begin
      mismatched++;
      $display("FAIL sw_data_hazard: got %b expected 01", {out_valid, hazard_stall});
    end
    tick();
    compared++;
    if ({out_valid, out_mem_write, hazard_stall, out_pc} !== {3'b110, 16'h0062}) begin
      mismatched++;
      $display("FAIL sw_after_bubble: got %h expected %h",
               {out_valid, out_mem_write, hazard_stall, out_pc}, {3'b110, 16'h0062});
    end
  endtask

  task automatic test_stall_flush();
    logic [51:0] exp;
    drive(1'b1, 16'h0650, 16'h0070);
    tick();
    exp = exp_b(1, 0, 3, 1, 2, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0070);
    ex_stall = 1'b1;
    drive(1'b1, 16'h547F, 16'h0072);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
      tick();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    flush = 1'b1;
    tick();
    compared++;
    if (obs !== 52'h0) begin
      mismatched++;
      $display("FAIL flush_over_stall: got %h expected %h", obs, 52'h0);
    end
    flush = 1'b0;
    ex_stall = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_input_dropped: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_hazard();
    logic [51:0] exp;
    drive(1'b1, 16'h6842, 16'h0080);   // LW r4
    tick();
    drive(1'b1, 16'h0B08, 16'h0082);   // ADD r5,r4,r1
    tick();
    ex_stall = 1'b1;
    tick();
    compared++;
    if ({out_valid, hazard_stall} !== 2'b01) begin
      mismatched++;
      $display("FAIL hazard_hold_on_stall: got %b expected 01", {out_valid, hazard_stall});
    end
    rst = 1'b1;
    tick();
    compared++;
    if (obs !== 52'h0) begin
      mismatched++;
      $display("FAIL reset_mid_hazard: got %h expected %h", obs, 52'h0);
    end
    rst = 1'b0;
    ex_stall = 1'b0;
    tick();
    exp = exp_b(1, 0, 5, 4, 1, 16'h0, 0, 1, 0, 0, 0, 0, 16'h0082);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL after_reset_no_hazard: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_illegal_nop();
    drive(1'b1, 16'hA000, 16'h0090);
    tick();
    compared++;
    if (ctl !== 10'b1_0000_0_0_0_0_1) begin
      mismatched++;
      $display("FAIL illegal_opcode: got %b expected %b", ctl, 10'b1_0000_0_0_0_0_1);
    end
    drive(1'b1, 16'hF000, 16'h0092);
    tick();
    compared++;
    if (ctl !== 10'b1_0000_0_0_0_0_0) begin
      mismatched++;
      $display("FAIL nop_opcode: got %b expected %b", ctl, 10'b1_0000_0_0_0_0_0);
    end
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    compared++;
    if ({out_valid, hazard_stall} !== 2'b00) begin
      mismatched++;
      $display("FAIL idle_bubble: got %b expected 00", {out_valid, hazard_stall});
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    test_reset();
    test_rtype();
    test_immediate();
    test_load_use();
    test_stall_flush();
    test_reset_mid_hazard();
    test_illegal_nop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
